// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared states, flag positions, opcodes and frame sizes for the UART/ALU sequencer.
package alu_ctrl_pkg;
    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
    } state_e;
    localparam int FLG_C = 2;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 0;
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam int RX_BYTES = 3;
    localparam int TX_BYTES = 2;
    function automatic logic [7:0] pack_flags(input logic [2:0] cvz);
        return {5'b0, cvz[FLG_C], cvz[FLG_V], cvz[FLG_Z]};
    endfunction
endpackage

// File: rtl/inter_byte_timer.sv
// inter_byte_timer: counts enabled cycles since the last clear and flags the final count.
module inter_byte_timer #(
    parameter int TIMEOUT = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else if (clear) cnt_q <= '0;
        else if (enable) cnt_q <= cnt_q + W'(1);
    end
    assign expired = enable && (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects an (A, B, opcode) frame from UART RX, runs the ALU, returns result and flags via UART TX.
module uart_alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int N       = 8,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_done,
    input  logic         i_tx_done,
    output logic         o_tx_start,
    output logic [7:0]   o_tx_data,
    output logic [N-1:0] o_alu_a,
    output logic [N-1:0] o_alu_b,
    output logic [5:0]   o_alu_op,
    input  logic [N-1:0] i_alu_result,
    input  logic [2:0]   i_alu_flags,
    output logic         o_busy,
    output logic         o_err
);
    state_e       state_q;
    logic [N-1:0] a_q, b_q;
    logic [5:0]   op_q;
    logic [7:0]   tx_data_q, flg_q;
    logic         tx_start_q, busy_q, err_q;
    logic         waiting, expired;
    assign waiting = (state_q == WAIT_B) || (state_q == WAIT_OP);
    // Counter sits at zero outside the byte-wait states and restarts on every accepted byte.
    inter_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(!waiting || i_rx_done),
        .enable(waiting),
        .expired(expired)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            flg_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                WAIT_A: if (i_rx_done) begin
                    a_q     <= i_rx_data;
                    state_q <= WAIT_B;
                end
                WAIT_B: if (i_rx_done) begin
                    b_q     <= i_rx_data;
                    state_q <= WAIT_OP;
                end else if (expired) begin
                    err_q   <= 1'b1;
                    state_q <= WAIT_A;
                end
                WAIT_OP: if (i_rx_done) begin
                    if (i_rx_data[7:6] == 2'b00) begin
                        op_q    <= i_rx_data[5:0];
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= WAIT_A;
                    end
                end else if (expired) begin
                    err_q   <= 1'b1;
                    state_q <= WAIT_A;
                end
                EXEC: begin
                    tx_data_q  <= i_alu_result;
                    flg_q      <= pack_flags(i_alu_flags);
                    tx_start_q <= 1'b1;
                    state_q    <= SEND_RES;
                end
                SEND_RES: state_q <= WAIT_RES;
                WAIT_RES: if (i_tx_done) begin
                    tx_data_q  <= flg_q;
                    tx_start_q <= 1'b1;
                    state_q    <= SEND_FLG;
                end
                SEND_FLG: state_q <= WAIT_FLG;
                WAIT_FLG: if (i_tx_done) begin
                    busy_q  <= 1'b0;
                    state_q <= WAIT_A;
                end
                default: state_q <= WAIT_A;
            endcase
        end
    end
    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_alu_a    = a_q;
    assign o_alu_b    = b_q;
    assign o_alu_op   = op_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;
endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Frame sequencer between the UART receiver/transmitter and the N-bit ALU.
- Collects a 3-byte command frame (A, B, opcode) from the UART RX, drives the ALU operand/opcode inputs from internal registers and samples the combinational ALU outputs.
- Returns a 2-byte response (result, flags) through the UART TX.
- Replaces the switch/button loading path so the ALU can be exercised from a host PC.

## Interface
- N, 8, ALU data width; frame bytes are 8 bits, so N must be 8.
- TIMEOUT, 100_000_000, inter-byte timeout in clk cycles (1 s at 100 MHz); must be ≥2.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_rx_data  in  8  byte from UART RX; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse: new RX byte.
- i_tx_done  in  1  one-cycle pulse: TX finished shifting the current byte.
- o_tx_start  out  1  one-cycle pulse: TX loads o_tx_data.
- o_tx_data  out  8  byte to transmit; held stable until the matching i_tx_done.
- o_alu_a  out  N  operand A register.
- o_alu_b  out  N  operand B register.
- o_alu_op  out  6  opcode register.
- i_alu_result  in  N  combinational ALU result.
- i_alu_flags  in  3  {carry, overflow, zero}.
- o_busy  out  1  high in states EXEC through WAIT_FLG.
- o_err  out  1  one-cycle pulse on frame error or timeout.

## Operation
- Reset values:
  - All outputs 0.
  - Result/flag capture registers 0.
  - Timeout counter 0.
  - State WAIT_A.
- States and transitions:
  - WAIT_A: on i_rx_done, o_alu_a ← i_rx_data and timer cleared → WAIT_B.
  - WAIT_B: on i_rx_done, o_alu_b ← i_rx_data and timer cleared → WAIT_OP.
  - WAIT_OP: on i_rx_done, check the opcode byte:
    - bits [7:6] = 00: o_alu_op ← i_rx_data[5:0] → EXEC.
    - bits [7:6] ≠ 00: o_err pulse → WAIT_A; A/B/op registers keep their old values.
  - EXEC (exactly 1 cycle): capture res ← i_alu_result and flg ← {5'b0, carry, overflow, zero} → SEND_RES.
  - SEND_RES (1 cycle): o_tx_start=1, o_tx_data=res → WAIT_RES.
  - WAIT_RES: on i_tx_done → SEND_FLG.
  - SEND_FLG (1 cycle): o_tx_start=1, o_tx_data=flg → WAIT_FLG.
  - WAIT_FLG: on i_tx_done → WAIT_A.
- Timeout:
  - The counter runs only in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT-1 without i_rx_done: o_err pulse → WAIT_A, partial frame discarded.
  - The counter is cleared on every state change.
- Opcode legality beyond bits [7:6] is not checked; unknown codes go to the ALU as-is and the ALU's default response is returned.
- Flags byte layout: bit2 = C, bit1 = V, bit0 = Z, bits 7:3 = 0.

## Timing
- Op byte pulse in cycle t:
  - o_alu_op valid from t+1; state EXEC in t+1.
  - Result captured at the end of t+1.
  - o_tx_start high in t+2.
- From i_tx_done of the result byte in cycle u: state SEND_FLG in u+1, so the second o_tx_start is high in u+1.
- After i_tx_done of the flags byte, the next frame can be accepted from the following cycle; no gap is required.
- o_tx_data changes only on entry to SEND_RES / SEND_FLG.
- Boundary conditions:
  - i_rx_done in EXEC..WAIT_FLG: byte dropped silently; no error, no state change.
  - i_rx_done in the same cycle the timeout count hits: the byte wins, no error.
  - i_tx_done outside WAIT_RES/WAIT_FLG: ignored.
  - reset asserted mid-frame or mid-send: all registers and outputs go to their reset values immediately, without waiting for clk. o_tx_start drops at once; a TX byte already started is not aborted by this block.
  - A timeout error and a bad-opcode error cannot coincide; each produces a single o_err pulse.

## Structure
- Package alu_ctrl_pkg:
  - State enum (8 states, 3-bit encoding).
  - Flag bit positions (FLG_C=2, FLG_V=1, FLG_Z=0).
  - Opcode constants: ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRL 6'h02, SRA 6'h03.
  - Frame length constant (3 RX bytes, 2 TX bytes).
- Sub-module inter_byte_timer:
  - Parameter TIMEOUT.
  - Inputs clk, reset, clear, enable; output expired.
  - Width $clog2(TIMEOUT).
- Everything else (FSM and capture registers) sits in uart_alu_ctrl.

## Test plan
- ADD 5+3: RX 0x05, 0x03, 0x20 with a behavioural TX model (i_tx_done 10 cycles after each start) → TX bytes 0x08 then 0x00; o_busy high from EXEC to the last i_tx_done.
- Carry/zero: RX 0xFF, 0x01, 0x20 → TX 0x00 then 0x05; SUB 0x80−0x01 (op 0x22) → TX 0x7F, flags byte with V=1.
- Bad opcode: RX 0x01, 0x02, 0xE0 → one o_err pulse, no o_tx_start, o_alu_op unchanged; a following valid frame works normally.
- Timeout with TIMEOUT=16: RX 0x11, then idle 16 cycles → o_err exactly once, state WAIT_A; RX at the expiring cycle → accepted, no error.
- RX during send: extra RX pulses in SEND_RES..WAIT_FLG → ignored; the next real frame is decoded correctly.
- Reset mid-send: assert reset in WAIT_RES → o_tx_start, o_busy and o_alu_* are 0 before the next clk edge; after release a full frame completes.
